btn_step_gen: RTL and testbench
===============================

# btn_step_gen

Button-to-step conditioner that produces the clock-enable side of the lab flip-flop exercise. It synchronizes and debounces the centre pushbutton, emits exactly one single-cycle step pulse per confirmed press, and snapshots the switch bank on that pulse. It sits between the board inputs (`btnC`, `sw`) and the flip-flop bank, so each D/JK/T stage advances once per physical press and sees stable inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronized samples required to accept a press or release. Legal range ≥ 1.
- `SW_WIDTH`, default 4: width of the switch bank.
- `COUNT_WIDTH`, default 8: width of the press counter.

- `Clk`  input  1  system clock; all state updates on the rising edge.
- `Rst_n`  input  1  asynchronous, active-low reset.
- `Btn`  input  1  raw, asynchronous, bouncing pushbutton (1 = pressed).
- `Sw`  input  SW_WIDTH  raw asynchronous switch levels.
- `Step`  output  1  one-cycle pulse per accepted press.
- `Level`  output  1  debounced button level.
- `SwLatched`  output  SW_WIDTH  synchronized `Sw`, captured on the `Step` edge.
- `PressCount`  output  COUNT_WIDTH  number of accepted presses, modulo 2^COUNT_WIDTH.

## Operation
- Synchronizers:
  - Two-flop synchronizer on `Btn`, producing `b_s`.
  - Independent two-flop synchronizer per `Sw` bit, producing `sw_s`.
- Debounce counter `cnt` has width ceil(log2(DEBOUNCE_CYCLES+1)).
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE:
    - `b_s`=1 → PRESS_WAIT, `cnt`←1.
    - Otherwise stay.
  - PRESS_WAIT:
    - `b_s`=0 → IDLE. No pulse.
    - `b_s`=1 and `cnt`==DEBOUNCE_CYCLES → HELD. On this edge: `Step`←1, `Level`←1, `SwLatched`←`sw_s`, `PressCount`←`PressCount`+1.
    - Otherwise `cnt`←`cnt`+1.
  - HELD:
    - `b_s`=0 → RELEASE_WAIT, `cnt`←1.
    - Otherwise stay.
  - RELEASE_WAIT:
    - `b_s`=1 → HELD. No pulse; `Level` stays 1.
    - `b_s`=0 and `cnt`==DEBOUNCE_CYCLES → IDLE, `Level`←0.
    - Otherwise `cnt`←`cnt`+1.
- `Step` is registered and clears on the next edge. It never stays high for two consecutive cycles.
- `SwLatched` and `PressCount` change only on the `Step` edge. Between presses they hold.
- `PressCount` wraps from 2^COUNT_WIDTH−1 to 0 with no flag.
- Unreachable state encodings → IDLE on the next edge.
- Reset (`Rst_n`=0, any time, asynchronous):
  - State IDLE; `cnt`, synchronizer flops, `Step`, `Level`, `SwLatched`, `PressCount` all 0.
  - Reset mid-debounce discards the in-progress press.
  - A button still held after reset release is accepted as a new press through the normal path.

## Timing
- Reset values: `Step`=0, `Level`=0, `SwLatched`=0, `PressCount`=0.
- Press latency, with `Btn` rising before edge E0 and held stable:
  - `b_s`=1 after E1.
  - PRESS_WAIT entered at E2.
  - `Step`, `Level` and `PressCount` update at edge E(DEBOUNCE_CYCLES+2).
  - `Step` falls at E(DEBOUNCE_CYCLES+3).
- Release latency: `Level` falls DEBOUNCE_CYCLES+2 edges after the first edge sampling `Btn`=0 stably.
- Any bounce shorter than DEBOUNCE_CYCLES cycles produces no `Step` and no `Level` change.
- `SwLatched` reflects `Sw` as it was at least 2 edges before the `Step` edge.
- Throughput: at most one `Step` per press/release cycle. Minimum spacing between `Step` pulses is 2·DEBOUNCE_CYCLES+2 cycles.

## Test plan
- DEBOUNCE_CYCLES=4, reset, then `Btn`=1 held → `Step`=1 for exactly one cycle at edge 6 after the first sampling edge; `Level`=1 from edge 6; `PressCount`=1.
- DEBOUNCE_CYCLES=4, `Btn` toggling 1,0,1,0 at 2-cycle intervals, then 0 → no `Step`, `Level`=0, `PressCount`=0.
- `Sw`=4'b1010 stable, press; then `Sw`=4'b0101 while HELD → `SwLatched`=4'b1010 until the next press, then 4'b0101.
- Held press with a 2-cycle release glitch (DEBOUNCE_CYCLES=4) → `Level` stays 1, no second `Step`, `PressCount` unchanged.
- COUNT_WIDTH=8, 257 clean presses → `PressCount` reads 255 after press 255, 0 after press 256, 1 after press 257.
- `Rst_n` pulsed low at `cnt`=2 in PRESS_WAIT with `Btn` held → all outputs 0 immediately; after release, `Step` at edge DEBOUNCE_CYCLES+2 and `PressCount`=1.

Source files
------------

// File: rtl/btn_step_gen_if.sv
// Board-side signal bundle for the button step generator: raw button and
// switches in, step pulse, debounced level, switch snapshot and press count out.
interface btn_step_gen_if #(
   parameter int SW_WIDTH    = 4,
   parameter int COUNT_WIDTH = 8
);
   logic                   Btn;
   logic [SW_WIDTH-1:0]    Sw;
   logic                   Step;
   logic                   Level;
   logic [SW_WIDTH-1:0]    SwLatched;
   logic [COUNT_WIDTH-1:0] PressCount;

   modport master (
      output Btn, Sw,
      input  Step, Level, SwLatched, PressCount
   );

   modport slave (
      input  Btn, Sw,
      output Step, Level, SwLatched, PressCount
   );
endinterface

// File: rtl/btn_step_gen.sv
// Centre-button conditioner: synchronizes and debounces Btn, emits one Step per
// accepted press, snapshots the synchronized switches and counts presses.
module btn_step_gen #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SW_WIDTH        = 4,
   parameter int COUNT_WIDTH     = 8
) (
   input  logic          Clk,
   input  logic          Rst_n,
   btn_step_gen_if.slave io
);
   localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);
   localparam logic [COUNT_WIDTH-1:0] PC_ONE  = COUNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic                   btn_p0_q, btn_p0_d, btn_p1_q, btn_p1_d;
   logic [SW_WIDTH-1:0]    sw_p0_q, sw_p0_d, sw_p1_q, sw_p1_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   step_q, step_d;
   logic                   level_q, level_d;
   logic [SW_WIDTH-1:0]    swl_q, swl_d;
   logic [COUNT_WIDTH-1:0] press_cnt_q, press_cnt_d;

   always_comb begin
      btn_p0_d    = io.Btn;
      btn_p1_d    = btn_p0_q;
      sw_p0_d     = io.Sw;
      sw_p1_d     = sw_p0_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      step_d      = 1'b0;
      level_d     = level_q;
      swl_d       = swl_q;
      press_cnt_d = press_cnt_q;

      // btn_p1_q is the synchronized button; cnt counts stable samples seen so far
      case (state_q)
         IDLE: begin
            if (btn_p1_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!btn_p1_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               state_d     = HELD;
               step_d      = 1'b1;
               level_d     = 1'b1;
               swl_d       = sw_p1_q;
               press_cnt_d = press_cnt_q + PC_ONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!btn_p1_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (btn_p1_q) begin
               state_d = HELD;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         btn_p0_q    <= 1'b0;
         btn_p1_q    <= 1'b0;
         sw_p0_q     <= '0;
         sw_p1_q     <= '0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         step_q      <= 1'b0;
         level_q     <= 1'b0;
         swl_q       <= '0;
         press_cnt_q <= '0;
      end else begin
         btn_p0_q    <= btn_p0_d;
         btn_p1_q    <= btn_p1_d;
         sw_p0_q     <= sw_p0_d;
         sw_p1_q     <= sw_p1_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
         level_q     <= level_d;
         swl_q       <= swl_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   assign io.Step       = step_q;
   assign io.Level      = level_q;
   assign io.SwLatched  = swl_q;
   assign io.PressCount = press_cnt_q;
endmodule

// File: tb/tb_btn_step_gen.sv
// Bench for btn_step_gen: fixed vector table, hand-written corner sequences and
// random button/switch activity compared against a run-length debounce model.
module tb_btn_step_gen;
   localparam int D  = 4;
   localparam int SW = 4;
   localparam int CW = 8;

   logic Clk = 1'b0;
   logic Rst_n;

   btn_step_gen_if #(.SW_WIDTH(SW), .COUNT_WIDTH(CW)) bus ();

   btn_step_gen #(
      .DEBOUNCE_CYCLES(D),
      .SW_WIDTH       (SW),
      .COUNT_WIDTH    (CW)
   ) dut (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .io   (bus)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          btn;
      logic [SW-1:0] sw;
      logic          step;
      logic          level;
      logic [SW-1:0] swl;
      logic [CW-1:0] cnt;
   } vec_t;
   vec_t vecs[$];

   // Reference: Level flips after D+1 consecutive synchronized samples that
   // disagree with it; a 0->1 flip is a press.
   logic          m_b1, m_b2, m_level, m_step, m_prev_step;
   logic [SW-1:0] m_sw1, m_sw2, m_swl;
   logic [CW-1:0] m_cnt;
   int            m_run;

   logic rb;
   int   rlen;
   int   cyc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_b1 = 0; m_b2 = 0; m_level = 0; m_step = 0; m_prev_step = 0;
      m_sw1 = '0; m_sw2 = '0; m_swl = '0; m_cnt = '0; m_run = 0;
   endtask

   task automatic model_edge();
      m_step = 1'b0;
      if (m_b2 != m_level) begin
         m_run++;
         if (m_run == D + 1) begin
            m_level = ~m_level;
            m_run   = 0;
            if (m_level) begin
               m_step = 1'b1;
               m_swl  = m_sw2;
               m_cnt  = m_cnt + 1;
            end
         end
      end else begin
         m_run = 0;
      end
      m_b2  = m_b1;
      m_b1  = bus.Btn;
      m_sw2 = m_sw1;
      m_sw1 = bus.Sw;
   endtask

   task automatic tick();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      chk("model_step",  32'(bus.Step),       32'(m_step));
      chk("model_level", 32'(bus.Level),      32'(m_level));
      chk("model_swl",   32'(bus.SwLatched),  32'(m_swl));
      chk("model_cnt",   32'(bus.PressCount), 32'(m_cnt));
      if (m_prev_step) chk("step_double", 32'(bus.Step), 32'd0);
      m_prev_step = bus.Step;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      #1;
      chk("rst_step",  32'(bus.Step),       32'd0);
      chk("rst_level", 32'(bus.Level),      32'd0);
      chk("rst_swl",   32'(bus.SwLatched),  32'd0);
      chk("rst_cnt",   32'(bus.PressCount), 32'd0);
      model_reset();
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic add(input logic b, input logic [SW-1:0] s, input logic st,
                      input logic lv, input logic [SW-1:0] sl, input logic [CW-1:0] c);
      vec_t v;
      v.btn = b; v.sw = s; v.step = st; v.level = lv; v.swl = sl; v.cnt = c;
      vecs.push_back(v);
   endtask

   task automatic hold(input logic b, input int n);
      bus.Btn = b;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      Rst_n   = 1'b1;
      bus.Btn = 1'b0;
      bus.Sw  = '0;
      model_reset();
      #2;
      do_reset();

      // Clean press, glitchy release, full release, bounce, second press.
      for (int k = 0; k < 6; k++) add(1, 4'hA, 0, 0, 4'h0, 0);
      add(1, 4'hA, 1, 1, 4'hA, 1);
      add(1, 4'hA, 0, 1, 4'hA, 1);
      for (int k = 0; k < 2; k++) add(0, 4'h5, 0, 1, 4'hA, 1);
      for (int k = 0; k < 4; k++) add(1, 4'h5, 0, 1, 4'hA, 1);
      for (int k = 0; k < 6; k++) add(0, 4'h5, 0, 1, 4'hA, 1);
      add(0, 4'h5, 0, 0, 4'hA, 1);
      for (int k = 0; k < 12; k++) add((k < 8) && ((k / 2) % 2 == 0), 4'h5, 0, 0, 4'hA, 1);
      for (int k = 0; k < 6; k++) add(1, 4'h5, 0, 0, 4'hA, 1);
      add(1, 4'h5, 1, 1, 4'h5, 2);
      add(1, 4'h5, 0, 1, 4'h5, 2);

      foreach (vecs[i]) begin
         bus.Btn = vecs[i].btn;
         bus.Sw  = vecs[i].sw;
         tick();
         chk($sformatf("vec%0d_step", i),  32'(bus.Step),       32'(vecs[i].step));
         chk($sformatf("vec%0d_level", i), 32'(bus.Level),      32'(vecs[i].level));
         chk($sformatf("vec%0d_swl", i),   32'(bus.SwLatched),  32'(vecs[i].swl));
         chk($sformatf("vec%0d_cnt", i),   32'(bus.PressCount), 32'(vecs[i].cnt));
      end

      // Reset two samples into a press, button kept down through and after reset.
      hold(0, 8);
      hold(1, 4);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rstmid_step", 32'(bus.Step), (i == 6) ? 32'd1 : 32'd0);
         chk("rstmid_cnt",  32'(bus.PressCount), (i >= 6) ? 32'd1 : 32'd0);
      end
      hold(0, 8);

      // Counter wrap over 257 presses.
      do_reset();
      for (int n = 1; n <= 257; n++) begin
         bus.Sw = SW'($urandom);
         hold(1, 8);
         if (n == 255) chk("wrap_255", 32'(bus.PressCount), 32'd255);
         if (n == 256) chk("wrap_256", 32'(bus.PressCount), 32'd0);
         if (n == 257) chk("wrap_257", 32'(bus.PressCount), 32'd1);
         hold(0, 8);
      end

      // Random segments of arbitrary length against the model.
      cyc = 0;
      while (cyc < 3000) begin
         rb   = 1'($urandom_range(0, 1));
         rlen = $urandom_range(1, 12);
         for (int j = 0; j < rlen; j++) begin
            bus.Btn = rb;
            bus.Sw  = SW'($urandom);
            tick();
            cyc++;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
